// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory pipeline stage: writeback source codes,
// data-bus FSM states and the control half of the M pipeline register.
package memory_stage_pkg;

  localparam logic [1:0] WB_SRC_ALU = 2'b00;
  localparam logic [1:0] WB_SRC_MEM = 2'b01;
  localparam logic [1:0] WB_SRC_PC  = 2'b10;

  typedef enum logic [2:0] {
    DBUS_IDLE  = 3'd0,
    DBUS_REQ   = 3'd1,
    DBUS_WAIT  = 3'd2,
    DBUS_DONE  = 3'd3,
    DBUS_DRAIN = 3'd4
  } dbus_state_e;

  typedef struct packed {
    logic       pc_write;
    logic       rd_write;
    logic [1:0] rd_write_src;
    logic       mem_write;
    logic [4:0] rd;
  } m_ctrl_t;

  // An instruction touches data memory if it stores or writes back load data.
  function automatic logic is_mem_op(input logic mem_write, input logic [1:0] wb_src);
    return mem_write | (wb_src == WB_SRC_MEM);
  endfunction

  // Writeback source codes that the writeback mux understands.
  function automatic logic is_known_wb_src(input logic [1:0] wb_src);
    return (wb_src == WB_SRC_ALU) || (wb_src == WB_SRC_MEM) || (wb_src == WB_SRC_PC);
  endfunction

  // The stage holds upstream while the bus FSM is in any of these states.
  function automatic logic is_busy_state(input dbus_state_e s);
    return (s == DBUS_REQ) || (s == DBUS_WAIT) || (s == DBUS_DRAIN);
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data bus between the memory stage (master) and data memory (slave):
// req/gnt request handshake followed by an rvalid-qualified read return.
interface memory_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/memory_stage_dbus_master.sv
// Data-bus master for the memory stage: sequences one word access per
// instruction held in the M register, captures load data and reports busy.
module dbus_master
  import memory_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,    // M register accepts a new instruction
  input  logic            mem_op_i,  // that instruction accesses memory
  input  logic            flush_i,   // M register is being bubbled
  input  logic            we_i,      // held instruction is a store
  input  logic [XLEN-1:0] addr_i,    // held effective address
  input  logic [XLEN-1:0] wdata_i,   // held store data
  output logic            busy_o,
  output logic [XLEN-1:0] rdata_o,
  memory_stage_if.master  bus
);

  dbus_state_e     state_q, state_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  // State and captured load data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DBUS_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic for the access sequence, including flush recovery.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DBUS_IDLE, DBUS_DONE: begin
        if (flush_i)     state_d = DBUS_IDLE;
        else if (load_i) state_d = mem_op_i ? DBUS_REQ : DBUS_IDLE;
      end
      DBUS_REQ: begin
        // A granted load owes us a response even when flushed, so drain it.
        if (flush_i)        state_d = (bus.gnt && !we_i) ? DBUS_DRAIN : DBUS_IDLE;
        else if (bus.gnt)   state_d = we_i ? DBUS_DONE : DBUS_WAIT;
      end
      DBUS_WAIT: begin
        // A response arriving with the flush is already consumed here.
        if (flush_i)         state_d = bus.rvalid ? DBUS_IDLE : DBUS_DRAIN;
        else if (bus.rvalid) state_d = DBUS_DONE;
      end
      DBUS_DRAIN: begin
        if (bus.rvalid) state_d = DBUS_IDLE;
      end
      default: state_d = DBUS_IDLE;
    endcase
  end

  // Load data is captured only for an unflushed response in WAIT.
  always_comb begin
    rdata_d = rdata_q;
    if ((state_q == DBUS_WAIT) && bus.rvalid && !flush_i) rdata_d = bus.rdata;
  end

  // Bus drive and busy flag decoded from the current state.
  always_comb begin
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    busy_o    = is_busy_state(state_q);
    if (state_q == DBUS_REQ) begin
      bus.req   = 1'b1;
      bus.we    = we_i;
      bus.addr  = {addr_i[XLEN-1:2], 2'b00};
      bus.wdata = wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// MEMORY pipeline stage: M pipeline register plus the data-bus master.
// Stalls itself while a data access is outstanding.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write_e,
  input  logic            rd_write_e,
  input  logic [1:0]      rd_write_src_e,
  input  logic            mem_write_e,
  input  logic [4:0]      rd_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] alu_res_e,
  input  logic [XLEN-1:0] mem_data_e,
  input  logic            stall_m,
  input  logic            flush_m,
  output logic            pc_write_m,
  output logic            rd_write_m,
  output logic [1:0]      rd_write_src_m,
  output logic [4:0]      rd_m,
  output logic [XLEN-1:0] pc_m,
  output logic [XLEN-1:0] alu_res_m,
  output logic [XLEN-1:0] mem_rdata_m,
  output logic            mem_busy_m,
  memory_stage_if.master  dbus
);

  m_ctrl_t         ctrl_q, ctrl_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] alu_res_q, alu_res_d;
  logic [XLEN-1:0] mem_data_q, mem_data_d;
  logic            load_en;
  logic            mem_op_e;

  assign load_en  = !stall_m && !mem_busy_m;
  assign mem_op_e = is_mem_op(mem_write_e, rd_write_src_e);

  // M pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      pc_q       <= '0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      alu_res_q  <= alu_res_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Flush bubbles the register ahead of any load; otherwise load when free.
  always_comb begin
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    alu_res_d  = alu_res_q;
    mem_data_d = mem_data_q;
    if (flush_m) begin
      ctrl_d     = '0;
      pc_d       = '0;
      alu_res_d  = '0;
      mem_data_d = '0;
    end else if (load_en) begin
      ctrl_d.pc_write     = pc_write_e;
      ctrl_d.rd_write     = rd_write_e;
      ctrl_d.rd_write_src = rd_write_src_e;
      ctrl_d.mem_write    = mem_write_e;
      ctrl_d.rd           = rd_e;
      pc_d                = pc_e;
      alu_res_d           = alu_res_e;
      mem_data_d          = mem_data_e;
    end
  end

  dbus_master #(.XLEN(XLEN)) u_dbus_master (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_en),
    .mem_op_i (mem_op_e),
    .flush_i  (flush_m),
    .we_i     (ctrl_q.mem_write),
    .addr_i   (alu_res_q),
    .wdata_i  (mem_data_q),
    .busy_o   (mem_busy_m),
    .rdata_o  (mem_rdata_m),
    .bus      (dbus)
  );

  // Writeback is suppressed until the access completes.
  always_comb begin
    pc_write_m     = ctrl_q.pc_write;
    rd_write_m     = ctrl_q.rd_write && !mem_busy_m;
    rd_write_src_m = ctrl_q.rd_write_src;
    rd_m           = ctrl_q.rd;
    pc_m           = pc_q;
    alu_res_m      = alu_res_q;
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: inputs change on the falling edge,
// registered outputs are observed on the falling edge before new drive.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pc_write_e, rd_write_e, mem_write_e, stall_m, flush_m;
  logic [1:0]      rd_write_src_e;
  logic [4:0]      rd_e;
  logic [XLEN-1:0] pc_e, alu_res_e, mem_data_e;
  logic            pc_write_m, rd_write_m, mem_busy_m;
  logic [1:0]      rd_write_src_m;
  logic [4:0]      rd_m;
  logic [XLEN-1:0] pc_m, alu_res_m, mem_rdata_m;

  int checks = 0;
  int errors = 0;

  memory_stage_if #(.XLEN(XLEN)) dbus_if ();

  memory_stage #(.XLEN(XLEN)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_write_e     (pc_write_e),
    .rd_write_e     (rd_write_e),
    .rd_write_src_e (rd_write_src_e),
    .mem_write_e    (mem_write_e),
    .rd_e           (rd_e),
    .pc_e           (pc_e),
    .alu_res_e      (alu_res_e),
    .mem_data_e     (mem_data_e),
    .stall_m        (stall_m),
    .flush_m        (flush_m),
    .pc_write_m     (pc_write_m),
    .rd_write_m     (rd_write_m),
    .rd_write_src_m (rd_write_src_m),
    .rd_m           (rd_m),
    .pc_m           (pc_m),
    .alu_res_m      (alu_res_m),
    .mem_rdata_m    (mem_rdata_m),
    .mem_busy_m     (mem_busy_m),
    .dbus           (dbus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_bubble();
    pc_write_e = 1'b0; rd_write_e = 1'b0; rd_write_src_e = WB_SRC_ALU;
    mem_write_e = 1'b0; rd_e = '0; pc_e = '0; alu_res_e = '0; mem_data_e = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [XLEN-1:0] res, input logic [XLEN-1:0] pc);
    drive_bubble();
    rd_write_e = 1'b1; rd_e = rd; alu_res_e = res; pc_e = pc;
  endtask

  task automatic drive_store(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data);
    drive_bubble();
    mem_write_e = 1'b1; alu_res_e = addr; mem_data_e = data;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [XLEN-1:0] addr);
    drive_bubble();
    rd_write_e = 1'b1; rd_write_src_e = WB_SRC_MEM; rd_e = rd; alu_res_e = addr;
  endtask

  task automatic bus_quiet();
    dbus_if.gnt = 1'b0; dbus_if.rvalid = 1'b0; dbus_if.rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_m = 1'b0; flush_m = 1'b0;
    drive_bubble(); bus_quiet();
    tick();
    checks++; if ({pc_write_m, rd_write_m, rd_write_src_m, rd_m, mem_busy_m} !== 10'd0) begin errors++; $display("FAIL reset_ctrl got=%0h exp=0", {pc_write_m, rd_write_m, rd_write_src_m, rd_m, mem_busy_m}); end
    checks++; if ({pc_m, alu_res_m, mem_rdata_m} !== 96'd0) begin errors++; $display("FAIL reset_data got=%0h exp=0", {pc_m, alu_res_m, mem_rdata_m}); end
    checks++; if (dbus_if.req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", dbus_if.req); end
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    drive_alu(5'd5, 32'h10, 32'h40);
    tick();
    checks++; if (rd_write_m !== 1'b1) begin errors++; $display("FAIL alu_rd_write got=%0b exp=1", rd_write_m); end
    checks++; if (alu_res_m !== 32'h10) begin errors++; $display("FAIL alu_res got=%0h exp=10", alu_res_m); end
    checks++; if (rd_m !== 5'd5 || pc_m !== 32'h40) begin errors++; $display("FAIL alu_rd_pc got=%0d/%0h exp=5/40", rd_m, pc_m); end
    checks++; if (mem_busy_m !== 1'b0 || dbus_if.req !== 1'b0) begin errors++; $display("FAIL alu_busy_req got=%0b%0b exp=00", mem_busy_m, dbus_if.req); end
    drive_bubble();
    tick();
    checks++; if (rd_write_m !== 1'b0 || alu_res_m !== 32'h0) begin errors++; $display("FAIL bubble_load got=%0b/%0h exp=0/0", rd_write_m, alu_res_m); end
  endtask

  task automatic test_store();
    drive_store(32'h103, 32'hDEADBEEF);
    tick();
    checks++; if (dbus_if.req !== 1'b1 || dbus_if.we !== 1'b1) begin errors++; $display("FAIL store_req_we got=%0b%0b exp=11", dbus_if.req, dbus_if.we); end
    checks++; if (dbus_if.addr !== 32'h100) begin errors++; $display("FAIL store_addr got=%0h exp=100", dbus_if.addr); end
    checks++; if (dbus_if.wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_wdata got=%0h exp=deadbeef", dbus_if.wdata); end
    checks++; if (mem_busy_m !== 1'b1) begin errors++; $display("FAIL store_busy got=%0b exp=1", mem_busy_m); end
    dbus_if.gnt = 1'b1;
    drive_bubble();
    tick();
    checks++; if (mem_busy_m !== 1'b0 || dbus_if.req !== 1'b0) begin errors++; $display("FAIL store_done got=%0b%0b exp=00", mem_busy_m, dbus_if.req); end
    checks++; if (alu_res_m !== 32'h103) begin errors++; $display("FAIL store_hold_addr got=%0h exp=103", alu_res_m); end
    bus_quiet();
    tick();
  endtask

  task automatic test_load();
    int busy_cnt = 0;
    drive_load(5'd7, 32'h200);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k <= 6) begin
        busy_cnt += int'(mem_busy_m);
        checks++; if (rd_write_m !== 1'b0) begin errors++; $display("FAIL load_rdw_busy k=%0d got=%0b exp=0", k, rd_write_m); end
      end
      if (k == 2) begin
        checks++; if (dbus_if.req !== 1'b1 || dbus_if.we !== 1'b0 || dbus_if.addr !== 32'h200) begin errors++; $display("FAIL load_req got=%0b%0b/%0h exp=10/200", dbus_if.req, dbus_if.we, dbus_if.addr); end
        checks++; if (alu_res_m !== 32'h200 || rd_m !== 5'd7 || rd_write_src_m !== WB_SRC_MEM) begin errors++; $display("FAIL load_fields_busy got=%0h/%0d/%0d exp=200/7/1", alu_res_m, rd_m, rd_write_src_m); end
      end
      if (k == 5) begin
        checks++; if (dbus_if.req !== 1'b0) begin errors++; $display("FAIL load_wait_req got=%0b exp=0", dbus_if.req); end
      end
      if (k == 7) begin
        checks++; if (mem_busy_m !== 1'b0 || rd_write_m !== 1'b1) begin errors++; $display("FAIL load_done got=%0b%0b exp=01", mem_busy_m, rd_write_m); end
        checks++; if (mem_rdata_m !== 32'hCAFEF00D) begin errors++; $display("FAIL load_rdata got=%0h exp=cafef00d", mem_rdata_m); end
      end
      if (k == 1) drive_bubble();
      dbus_if.gnt    = (k == 3);
      dbus_if.rvalid = (k == 6);
      dbus_if.rdata  = (k == 6) ? 32'hCAFEF00D : 32'h0;
    end
    checks++; if (busy_cnt != 6) begin errors++; $display("FAIL load_busy_cycles got=%0d exp=6", busy_cnt); end
    bus_quiet();
    tick();
  endtask

  task automatic test_flush_drain();
    drive_load(5'd8, 32'h300);
    tick();
    drive_bubble();
    dbus_if.gnt = 1'b1;
    tick();
    checks++; if (mem_busy_m !== 1'b1 || dbus_if.req !== 1'b0) begin errors++; $display("FAIL drain_wait got=%0b%0b exp=10", mem_busy_m, dbus_if.req); end
    dbus_if.gnt = 1'b0; flush_m = 1'b1;
    tick();
    checks++; if (mem_busy_m !== 1'b1 || dbus_if.req !== 1'b0) begin errors++; $display("FAIL drain_busy got=%0b%0b exp=10", mem_busy_m, dbus_if.req); end
    checks++; if (rd_m !== 5'd0 || alu_res_m !== 32'h0 || rd_write_m !== 1'b0) begin errors++; $display("FAIL drain_cleared got=%0d/%0h/%0b exp=0/0/0", rd_m, alu_res_m, rd_write_m); end
    flush_m = 1'b0; dbus_if.rvalid = 1'b1; dbus_if.rdata = 32'h1234;
    tick();
    checks++; if (mem_busy_m !== 1'b0 || dbus_if.req !== 1'b0) begin errors++; $display("FAIL drain_idle got=%0b%0b exp=00", mem_busy_m, dbus_if.req); end
    checks++; if (mem_rdata_m !== 32'hCAFEF00D) begin errors++; $display("FAIL drain_rdata_kept got=%0h exp=cafef00d", mem_rdata_m); end
    bus_quiet();
    tick();
  endtask

  task automatic test_flush_req();
    drive_store(32'h400, 32'h55);
    tick();
    checks++; if (dbus_if.req !== 1'b1) begin errors++; $display("FAIL flreq_req got=%0b exp=1", dbus_if.req); end
    flush_m = 1'b1;
    drive_bubble();
    tick();
    checks++; if (dbus_if.req !== 1'b0 || mem_busy_m !== 1'b0 || dbus_if.we !== 1'b0) begin errors++; $display("FAIL flreq_withdrawn got=%0b%0b%0b exp=000", dbus_if.req, mem_busy_m, dbus_if.we); end
    flush_m = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (dbus_if.req !== 1'b0) begin errors++; $display("FAIL flreq_quiet k=%0d got=%0b exp=0", k, dbus_if.req); end
    end
  endtask

  task automatic test_reset_mid();
    drive_load(5'd9, 32'h500);
    tick();
    drive_bubble();
    checks++; if (dbus_if.req !== 1'b1) begin errors++; $display("FAIL rstmid_req got=%0b exp=1", dbus_if.req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({dbus_if.req, mem_busy_m, rd_write_m, rd_m, alu_res_m, mem_rdata_m} !== 72'd0) begin errors++; $display("FAIL rstmid_async got=%0h exp=0", {dbus_if.req, mem_busy_m, rd_write_m, rd_m, alu_res_m, mem_rdata_m}); end
    tick();
    rst_n = 1'b1;
    drive_alu(5'd3, 32'h77, 32'h80);
    tick();
    checks++; if (rd_write_m !== 1'b1 || alu_res_m !== 32'h77 || rd_m !== 5'd3 || mem_busy_m !== 1'b0) begin errors++; $display("FAIL rstmid_after got=%0b/%0h/%0d/%0b exp=1/77/3/0", rd_write_m, alu_res_m, rd_m, mem_busy_m); end
    drive_bubble();
  endtask

  task automatic test_stall_hold();
    drive_alu(5'd11, 32'h99, 32'h90);
    tick();
    stall_m = 1'b1;
    drive_alu(5'd12, 32'hAA, 32'hA0);
    tick();
    checks++; if (rd_m !== 5'd11 || alu_res_m !== 32'h99) begin errors++; $display("FAIL stall_hold got=%0d/%0h exp=11/99", rd_m, alu_res_m); end
    stall_m = 1'b0;
    tick();
    checks++; if (rd_m !== 5'd12 || alu_res_m !== 32'hAA) begin errors++; $display("FAIL stall_release got=%0d/%0h exp=12/aa", rd_m, alu_res_m); end
    drive_bubble();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_flush_drain();
    test_flush_req();
    test_reset_mid();
    test_stall_hold();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
